// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: datapath width, PC step, FSM states
// and the {pc, instr} buffer entry format.
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO of {pc, instr} entries; flush overrides push in the same cycle.
// Head output reads as zero while the FIFO is empty.
module fetch_unit_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

    // Upstream credit accounting must make this unreachable; a drop here would lose an instruction.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC ownership, credit-limited imem requests, response
// buffering and redirect flush with drop counting of stale responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_wdata;
    logic             req_fire;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        fifo_push  = 1'b0;

        // Credit counts both outstanding and buffered words so every live response has a slot.
        occupancy      = {1'b0, inflight_q} + {1'b0, fifo_count};
        imem_req_valid = (state_q != S_BOOT) && !redirect_valid
                         && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        req_fire       = imem_req_valid && imem_req_ready;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        case ({req_fire, imem_rsp_valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        if (imem_rsp_valid) begin
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end else begin
                fifo_push = 1'b1;
                rsp_pc_d  = rsp_pc_q + PC_STEP;
            end
        end

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_FLUSH: if (drop_cnt_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase

        // Snapshot after this cycle's accounting so only still-outstanding responses are dropped.
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            rsp_pc_d   = align_pc(redirect_pc);
            drop_cnt_d = inflight_d;
            if (state_q != S_BOOT) begin
                state_d = (inflight_d != '0) ? S_FLUSH : S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fifo_wdata = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign fifo_pop   = out_valid && out_ready;

    fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign imem_req_addr = fetch_pc_q;
    assign out_valid     = !fifo_empty;
    assign out_pc        = fifo_head.pc;
    assign out_instr     = fifo_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit: memory responder and output
// scoreboard are modelled as plain PC streams with a hashed instruction memory.
module tb_fetch_unit;

    localparam int unsigned DEPTH   = 2;
    localparam logic [31:0] BOOT_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_unit #(
        .RESET_PC   (BOOT_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cycle;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_req_pc, exp_out_pc, last_pop_pc;
    int live, pops, first_ov, pops_before;
    int ready_pct, oready_pct, lat_min, lat_max, redir_pct;
    bit saw_wrap, found;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        imem_req_ready = ($urandom_range(99) < ready_pct);
        out_ready      = ($urandom_range(99) < oready_pct);
        if (pend_addr.size() > 0 && pend_due[0] <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirect_valid = (redir_pct > 0) && ($urandom_range(99) < redir_pct);
        redirect_pc    = $urandom;
    endtask

    // One clock: observe at negedge, update the reference, drive next inputs after posedge.
    task automatic tick();
        @(negedge clk);
        if (cycle == 0) chk("boot_idle", {31'b0, imem_req_valid}, 32'd0);
        if (redirect_valid) chk("no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
        if (out_valid && first_ov < 0) first_ov = cycle;
        if (!out_valid) begin
            chk("idle_out_pc", out_pc, 32'd0);
            chk("idle_out_instr", out_instr, 32'd0);
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req_pc);
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cycle + int'($urandom_range(lat_max, lat_min)));
            exp_req_pc += 32'd4;
            live++;
        end
        if (out_valid && out_ready) begin
            chk("out_pc", out_pc, exp_out_pc);
            chk("out_instr", out_instr, memfn(exp_out_pc));
            if (out_pc == 32'd0 && last_pop_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            last_pop_pc = out_pc;
            exp_out_pc += 32'd4;
            pops++;
            live--;
        end
        if (imem_rsp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (redirect_valid) begin
            exp_req_pc = {redirect_pc[31:2], 2'b00};
            exp_out_pc = {redirect_pc[31:2], 2'b00};
            live = 0;
        end
        chk("credit_bound", {31'b0, (live <= int'(DEPTH))}, 32'd1);
        @(posedge clk);
        #1;
        cycle++;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle = 0;
        exp_req_pc = BOOT_PC;
        exp_out_pc = BOOT_PC;
        live = 0;
        first_ov = -1;
        drive_inputs();
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] want);
        pops_before = pops;
        for (int i = 0; i < 40 && pops == pops_before; i++) tick();
        chk({tag, "_seen"}, {31'b0, (pops != pops_before)}, 32'd1);
        chk({tag, "_pc"}, last_pop_pc, want);
    endtask

    initial begin
        ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
        pops = 0; last_pop_pc = '1; saw_wrap = 1'b0;
        do_reset();

        // 1: streaming from reset, first output three cycles after reset release
        repeat (20) tick();
        chk("first_out_latency", first_ov, 32'd3);
        chk("stream_alive", {31'b0, (pops > 0)}, 32'd1);

        // 2: decode stall fills exactly the credit window, then drains in order
        oready_pct = 0; out_ready = 1'b0;
        repeat (10) tick();
        chk("stall_fill", live, DEPTH);
        pops_before = pops;
        oready_pct = 100;
        repeat (20) tick();
        chk("stall_drain", {31'b0, (pops - pops_before >= int'(DEPTH))}, 32'd1);

        // 3: redirect with two responses still outstanding
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend_addr.size() == 2 && !imem_rsp_valid) found = 1'b1;
            else tick();
        end
        chk("two_inflight_found", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        wait_pop("redir_0x100", 32'h0000_0100);

        // 4: redirect coinciding with a pop and an arriving response
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_ready && imem_rsp_valid) found = 1'b1;
            else tick();
        end
        chk("pop_rsp_overlap_found", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        tick();
        wait_pop("redir_0x400", 32'h0000_0400);

        // 5: back-to-back redirects, the later target wins
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        wait_pop("redir_0x300", 32'h0000_0300);

        // 6: random handshakes across the 32-bit PC wrap, then random redirects
        ready_pct = 60; oready_pct = 70; lat_min = 1; lat_max = 4;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        for (int i = 0; i < 200 && !saw_wrap; i++) tick();
        chk("pc_wrap", {31'b0, saw_wrap}, 32'd1);
        redir_pct = 3;
        repeat (400) tick();
        redir_pct = 0;
        repeat (5) tick();

        // mid-operation reset restarts the stream at the reset PC
        do_reset();
        ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1; out_ready = 1'b1;
        wait_pop("post_reset", BOOT_PC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
